// File: rtl/rom_copy_pkg.sv
// rtl/rom_copy_pkg.sv - shared widths and FSM state types for the flash-to-RAM copy engine
package rom_copy_pkg;

    localparam int ROM_AW = 21;
    localparam int MEM_AW = 30;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_STALL
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_BUSY
    } wr_state_t;

endpackage

// File: rtl/rom_copy_buf.sv
// rtl/rom_copy_buf.sv - single-entry word buffer between the flash read side and the RAM write side
module rom_copy_buf
    import rom_copy_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // A write wins over a same-cycle read so drain and refill can share one edge.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (rd_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/rom_copy.sv
// rtl/rom_copy.sv - boot block-copy engine moving words from the flash ROM port to a RAM port
// Optional running checksum of copied words enabled by ROM_COPY_CHECKSUM_EN.
module rom_copy
    import rom_copy_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROM_AW-1:0] src_addr,
    input  logic [MEM_AW-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     checksum,
    output logic              rom_stb,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_data,
    input  logic              rom_ack,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_data,
    input  logic              mem_ack
);

    rd_state_t rd_state_q, rd_state_d;
    wr_state_t wr_state_q, wr_state_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rom_stb_q, rom_stb_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              mem_stb_q, mem_stb_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_data_q, mem_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

    logic          accept, buf_valid, buf_drain, buf_free, rd_due, rom_fire, last_wr;
    logic [DW-1:0] buf_data;

    assign accept    = start & ~busy_q;
    assign buf_drain = (wr_state_q == W_BUSY) & mem_ack;
    assign buf_free  = ~buf_valid | buf_drain;
    assign rd_due    = busy_q & (req_cnt_q < cnt_q);
    // Acks outside R_WAIT (e.g. a read left over from a reset) are ignored.
    assign rom_fire  = (rd_state_q == R_WAIT) & rom_ack;
    assign last_wr   = buf_drain & ((wr_cnt_q + CNT_W'(1)) == cnt_q);

    rom_copy_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rom_fire),
        .wr_data (rom_data),
        .rd_en   (buf_drain),
        .valid   (buf_valid),
        .data    (buf_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (rd_due) rd_state_d = buf_free ? R_WAIT : R_STALL;
            R_STALL: if (!busy_q) rd_state_d = R_IDLE;
                     else if (buf_free) rd_state_d = R_WAIT;
            R_WAIT:  if (rom_ack) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase

        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (buf_valid && busy_q) wr_state_d = W_BUSY;
            W_BUSY:  if (mem_ack) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

`ifdef ROM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum_q, checksum_d;
`endif

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        rom_stb_d  = rom_stb_q;
        rom_addr_d = rom_addr_q;
        mem_stb_d  = mem_stb_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cnt_d      = cnt_q;
        req_cnt_d  = req_cnt_q;
        wr_cnt_d   = wr_cnt_q;
`ifdef ROM_COPY_CHECKSUM_EN
        checksum_d = checksum_q;
`endif

        if (accept) begin
            if (count != '0) begin
                busy_d     = 1'b1;
                rom_addr_d = src_addr;
                mem_addr_d = dst_addr;
                cnt_d      = count;
                req_cnt_d  = '0;
                wr_cnt_d   = '0;
`ifdef ROM_COPY_CHECKSUM_EN
                checksum_d = '0;
`endif
            end else begin
                done_d = 1'b1;
            end
        end

        if ((rd_state_q != R_WAIT) && (rd_state_d == R_WAIT)) begin
            rom_stb_d = 1'b1;
            req_cnt_d = req_cnt_q + CNT_W'(1);
        end
        if (rom_fire) begin
            rom_stb_d  = 1'b0;
            rom_addr_d = rom_addr_q + ROM_AW'(1);
        end

        if ((wr_state_q == W_IDLE) && (wr_state_d == W_BUSY)) begin
            mem_stb_d  = 1'b1;
            mem_data_d = buf_data;
        end
        if (buf_drain) begin
            mem_stb_d  = 1'b0;
            mem_addr_d = mem_addr_q + MEM_AW'(1);
            wr_cnt_d   = wr_cnt_q + CNT_W'(1);
`ifdef ROM_COPY_CHECKSUM_EN
            checksum_d = checksum_q + mem_data_q;
`endif
        end

        if (last_wr) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        mem_we_d = mem_stb_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_stb_q  <= 1'b0;
            rom_addr_q <= '0;
            mem_stb_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cnt_q      <= '0;
            req_cnt_q  <= '0;
            wr_cnt_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            rom_stb_q  <= rom_stb_d;
            rom_addr_q <= rom_addr_d;
            mem_stb_q  <= mem_stb_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cnt_q      <= cnt_d;
            req_cnt_q  <= req_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

`ifdef ROM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end
    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_stb  = rom_stb_q;
    assign rom_we   = 1'b0;
    assign rom_addr = rom_addr_q;
    assign mem_stb  = mem_stb_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule
